// File: rtl/pc_redirect_unit.sv
// ---------------------------------------------------------------------------
// pc_redirect_unit
//
// Fetch-side PC generator and instruction-fetch sequencer. Owns the fetch PC,
// issues one outstanding request at a time on the instruction bus and keeps a
// single fetched instruction buffered toward IF/ID. When the memory-stage
// branch checker resolves a redirect, this block computes the new target,
// kills wrong-path state (including a response that is still in flight) and
// restarts fetch from the target.
//
// Optional feature (build macro PC_MISALIGN_TRAP_EN):
//   When defined, a redirect to a target whose low two bits are non-zero
//   raises the registered misalign_trap output and halts fetch until the next
//   redirect or reset. When undefined, the port does not exist and the target
//   is used exactly as computed.
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   reset          asynchronous, active-high reset
//   redirect_valid flush request from the branch checker
//   pc_select      PC source: 00 add4 (no redirect), 01 add_imm, 10 jalr
//   branch_pc      PC of the resolving instruction
//   imm            sign-extended immediate of the resolving instruction
//   jalr_base      forwarded rs1 value for jalr
//   stall_in       downstream stall, IF/ID not accepting
//   ireq_valid     instruction bus request valid
//   ireq_addr      instruction bus request address
//   ireq_ready     bus accepts the request this cycle
//   iresp_valid    bus response valid
//   iresp_data     fetched instruction word
//   if_valid       buffered instruction valid toward IF/ID
//   if_inst        buffered instruction word
//   if_pc          PC of the buffered instruction
//   flush_out      kill IF/ID and ID/EX this cycle
//   misalign_trap  (PC_MISALIGN_TRAP_EN only) misaligned redirect target seen
// ---------------------------------------------------------------------------
module pc_redirect_unit #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [1:0]  pc_select,
  input  logic [63:0] branch_pc,
  input  logic [63:0] imm,
  input  logic [63:0] jalr_base,
  input  logic        stall_in,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        ireq_ready,
  input  logic        iresp_valid,
  input  logic [31:0] iresp_data,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [63:0] if_pc,
  output logic        flush_out
`ifdef PC_MISALIGN_TRAP_EN
  ,
  output logic        misalign_trap
`endif
);

  localparam logic [1:0] PC_FROM_ADD4    = 2'b00;
  localparam logic [1:0] PC_FROM_ADD_IMM = 2'b01;
  localparam logic [1:0] PC_FROM_JALR    = 2'b10;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic        drop_q, drop_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic [63:0] if_pc_q, if_pc_d;

  logic        take;
  logic [63:0] target;
  logic        buf_free;
  logic        fetch_halt;
  logic        req_valid;
  logic        req_fire;
  logic        consume;

  // A redirect is only real when the checker selects a non-sequential PC.
  // Gating with reset keeps flush_out low while the block is held in reset.
  assign take = !reset && redirect_valid && (pc_select != PC_FROM_ADD4);

  // Redirect target. The jalr result has bit 0 cleared as the ISA requires;
  // any unused select encoding falls back to the pc-relative form.
  always_comb begin
    target = branch_pc + imm;
    if (pc_select == PC_FROM_JALR) begin
      target = (jalr_base + imm) & ~64'h1;
    end else if (pc_select == PC_FROM_ADD_IMM) begin
      target = branch_pc + imm;
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  logic trap_q, trap_d;
  logic misaligned;

  assign misaligned = (target[1:0] != 2'b00);
  assign fetch_halt = trap_q;

  // The trap is re-evaluated on every accepted redirect, so an aligned
  // redirect both clears it and lets fetch resume.
  always_comb begin
    trap_d = trap_q;
    if (take) begin
      trap_d = misaligned;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trap_q <= 1'b0;
    end else begin
      trap_q <= trap_d;
    end
  end

  assign misalign_trap = trap_q;
`else
  assign fetch_halt = 1'b0;
`endif

  // The buffer can take a new instruction if it is empty or is being drained
  // this cycle; a request is only issued when its result has a place to land.
  assign buf_free  = !if_valid_q || !stall_in;
  assign req_valid = !reset && (state_q == ST_IDLE) && buf_free && !take && !fetch_halt;
  assign req_fire  = req_valid && ireq_ready;
  assign consume   = if_valid_q && !stall_in;

  // Next-state logic. A redirect overrides everything else; in WAIT it must
  // still track the outstanding response so the wrong-path word is dropped
  // instead of being loaded into the buffer later.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    drop_d     = drop_q;
    if_valid_d = if_valid_q;
    if_inst_d  = if_inst_q;
    if_pc_d    = if_pc_q;

    if (consume) begin
      if_valid_d = 1'b0;
    end

    if (take) begin
      pc_d       = target;
      if_valid_d = 1'b0;
      if (state_q == ST_WAIT) begin
        if (iresp_valid) begin
          drop_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          drop_d = 1'b1;
        end
      end
    end else if (state_q == ST_IDLE) begin
      if (req_fire) begin
        state_d = ST_WAIT;
      end
    end else begin
      if (iresp_valid) begin
        state_d = ST_IDLE;
        if (drop_q) begin
          drop_d = 1'b0;
        end else begin
          if_inst_d  = iresp_data;
          if_pc_d    = pc_q;
          if_valid_d = 1'b1;
          pc_d       = pc_q + 64'd4;
        end
      end
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      drop_q     <= 1'b0;
      if_valid_q <= 1'b0;
      if_inst_q  <= 32'h0;
      if_pc_q    <= 64'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      drop_q     <= drop_d;
      if_valid_q <= if_valid_d;
      if_inst_q  <= if_inst_d;
      if_pc_q    <= if_pc_d;
    end
  end

  assign ireq_valid = req_valid;
  assign ireq_addr  = pc_q;
  assign if_valid   = if_valid_q;
  assign if_inst    = if_inst_q;
  assign if_pc      = if_pc_q;
  assign flush_out  = take;

  // The bus only ever answers the single outstanding request.
  a_resp_only_in_wait: assert property (
    @(posedge clk) disable iff (reset) iresp_valid |-> (state_q == ST_WAIT)
  );

endmodule

// File: tb/tb_pc_redirect_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_redirect_unit
//
// Directed bench for pc_redirect_unit. A small bus responder answers each
// accepted request after busLat cycles with a word derived from its address;
// the main sequence drives redirects, stalls and reset and compares outputs
// against hand-computed values half a cycle after each input change.
// ---------------------------------------------------------------------------
module tb_pc_redirect_unit;

  localparam logic [63:0] RESET_PC_TB = 64'h0000_0000_8000_0000;
  localparam logic [1:0]  SEL_ADD4    = 2'b00;
  localparam logic [1:0]  SEL_ADD_IMM = 2'b01;
  localparam logic [1:0]  SEL_JALR    = 2'b10;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [1:0]  pc_select;
  logic [63:0] branch_pc;
  logic [63:0] imm;
  logic [63:0] jalr_base;
  logic        stall_in;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        ireq_ready;
  logic        iresp_valid = 1'b0;
  logic [31:0] iresp_data  = 32'h0;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [63:0] if_pc;
  logic        flush_out;
`ifdef PC_MISALIGN_TRAP_EN
  logic        misalign_trap;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int busLat      = 1;
  int busCount    = 0;
  logic [63:0] busAddr = 64'h0;

  pc_redirect_unit dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .pc_select      (pc_select),
    .branch_pc      (branch_pc),
    .imm            (imm),
    .jalr_base      (jalr_base),
    .stall_in       (stall_in),
    .ireq_valid     (ireq_valid),
    .ireq_addr      (ireq_addr),
    .ireq_ready     (ireq_ready),
    .iresp_valid    (iresp_valid),
    .iresp_data     (iresp_data),
    .if_valid       (if_valid),
    .if_inst        (if_inst),
    .if_pc          (if_pc),
    .flush_out      (flush_out)
`ifdef PC_MISALIGN_TRAP_EN
    ,
    .misalign_trap  (misalign_trap)
`endif
  );

  always #5 clk = ~clk;

  // Instruction word the bus returns for a given address.
  function automatic logic [31:0] instWord(input logic [63:0] a);
    return a[31:0] ^ 32'h1357_9BDF;
  endfunction

  // Bus responder: latch the accepted request mid-cycle, then raise the
  // response busLat cycles later, just after the clock edge.
  always begin
    @(negedge clk);
    if (reset) begin
      busCount = 0;
    end else if (ireq_valid && ireq_ready) begin
      busCount = busLat;
      busAddr  = ireq_addr;
    end
    @(posedge clk);
    #1;
    if (!reset && busCount > 0) begin
      busCount = busCount - 1;
      if (busCount == 0) begin
        iresp_valid = 1'b1;
        iresp_data  = instWord(busAddr);
      end else begin
        iresp_valid = 1'b0;
      end
    end else begin
      iresp_valid = 1'b0;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic rv, input logic [1:0] sel, input logic [63:0] bpc,
                               input logic [63:0] im, input logic [63:0] base);
    redirect_valid = rv;
    pc_select      = sel;
    branch_pc      = bpc;
    imm            = im;
    jalr_base      = base;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    stall_in   = 1'b0;
    ireq_ready = 1'b0;
    applyStimulus(1'b0, SEL_ADD4, 64'h0, 64'h0, 64'h0);

    // Reset state.
    nextCycle();
    nextCycle();
    @(negedge clk);
    checkOutput("rst_ireq_valid", 64'(ireq_valid), 64'h0);
    checkOutput("rst_if_valid",   64'(if_valid),   64'h0);
    checkOutput("rst_if_inst",    64'(if_inst),    64'h0);
    checkOutput("rst_if_pc",      if_pc,           64'h0);
    checkOutput("rst_flush",      64'(flush_out),  64'h0);
    checkOutput("rst_ireq_addr",  ireq_addr,       RESET_PC_TB);
`ifdef PC_MISALIGN_TRAP_EN
    checkOutput("rst_trap",       64'(misalign_trap), 64'h0);
`endif

    // Sequential fetch on a one-cycle bus.
    nextCycle();
    reset      = 1'b0;
    ireq_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checkOutput("seq_if_valid", 64'(if_valid), 64'h1);
        checkOutput("seq_if_pc",    if_pc, RESET_PC_TB + 64'(4 * (i - 1)));
        checkOutput("seq_if_inst",  64'(if_inst), 64'(instWord(RESET_PC_TB + 64'(4 * (i - 1)))));
      end
      checkOutput("seq_req_valid", 64'(ireq_valid), 64'h1);
      checkOutput("seq_req_addr",  ireq_addr, RESET_PC_TB + 64'(4 * i));
      nextCycle();
      @(negedge clk);
      checkOutput("seq_wait_req",  64'(ireq_valid), 64'h0);
      checkOutput("seq_wait_ifv",  64'(if_valid),   64'h0);
      nextCycle();
    end

    // Stall with a full buffer: no request, buffer held.
    stall_in = 1'b1;
    @(negedge clk);
    checkOutput("stall_req",     64'(ireq_valid), 64'h0);
    checkOutput("stall_if_v",    64'(if_valid),   64'h1);
    checkOutput("stall_if_pc",   if_pc, 64'h8000_0008);
    nextCycle();
    @(negedge clk);
    checkOutput("stall2_req",    64'(ireq_valid), 64'h0);
    checkOutput("stall2_if_pc",  if_pc, 64'h8000_0008);
    checkOutput("stall2_inst",   64'(if_inst), 64'(instWord(64'h8000_0008)));
    nextCycle();
    stall_in = 1'b0;
    @(negedge clk);
    checkOutput("unstall_req",   64'(ireq_valid), 64'h1);
    checkOutput("unstall_addr",  ireq_addr, 64'h8000_000C);
    nextCycle();
    nextCycle();
    busLat = 3;
    @(negedge clk);
    checkOutput("c_if_pc",       if_pc, 64'h8000_000C);
    checkOutput("c_req_addr",    ireq_addr, 64'h8000_0010);

    // Redirect while waiting; the late response must be dropped.
    nextCycle();
    applyStimulus(1'b1, SEL_ADD_IMM, 64'h8000_0010, 64'h20, 64'h0);
    @(negedge clk);
    checkOutput("tw_flush",      64'(flush_out),  64'h1);
    checkOutput("tw_req",        64'(ireq_valid), 64'h0);
    nextCycle();
    applyStimulus(1'b0, SEL_ADD4, 64'h0, 64'h0, 64'h0);
    @(negedge clk);
    checkOutput("tw_flush_off",  64'(flush_out),  64'h0);
    checkOutput("tw_req2",       64'(ireq_valid), 64'h0);
    nextCycle();
    @(negedge clk);
    checkOutput("tw_resp_ifv",   64'(if_valid),   64'h0);
    checkOutput("tw_resp_req",   64'(ireq_valid), 64'h0);
    nextCycle();
    busLat = 1;
    @(negedge clk);
    checkOutput("tw_after_ifv",  64'(if_valid),   64'h0);
    checkOutput("tw_after_req",  64'(ireq_valid), 64'h1);
    checkOutput("tw_after_addr", ireq_addr, 64'h8000_0030);
    nextCycle();
    nextCycle();

    // Redirect in IDLE while the bus is ready: nothing accepted.
    applyStimulus(1'b1, SEL_JALR, 64'h0, 64'h4, 64'h8000_1001);
    @(negedge clk);
    checkOutput("ti_if_valid",   64'(if_valid),   64'h1);
    checkOutput("ti_if_pc",      if_pc, 64'h8000_0030);
    checkOutput("ti_flush",      64'(flush_out),  64'h1);
    checkOutput("ti_req",        64'(ireq_valid), 64'h0);
    nextCycle();
    applyStimulus(1'b0, SEL_ADD4, 64'h0, 64'h0, 64'h0);
    @(negedge clk);
    checkOutput("ti_ifv_killed", 64'(if_valid),   64'h0);
    checkOutput("ti_req2",       64'(ireq_valid), 64'h1);
    checkOutput("ti_addr",       ireq_addr, 64'h8000_1004);

    // Redirect coincident with the response.
    nextCycle();
    applyStimulus(1'b1, SEL_ADD_IMM, 64'h8000_2000, 64'h100, 64'h0);
    @(negedge clk);
    checkOutput("tc_flush",      64'(flush_out),  64'h1);
    nextCycle();
    applyStimulus(1'b0, SEL_ADD4, 64'h0, 64'h0, 64'h0);
    @(negedge clk);
    checkOutput("tc_ifv",        64'(if_valid),   64'h0);
    checkOutput("tc_req",        64'(ireq_valid), 64'h1);
    checkOutput("tc_addr",       ireq_addr, 64'h8000_2100);

    // redirect_valid with add4 is a no-op.
    nextCycle();
    applyStimulus(1'b1, SEL_ADD4, 64'h8000_3000, 64'h40, 64'h0);
    @(negedge clk);
    checkOutput("a4_flush",      64'(flush_out),  64'h0);
    nextCycle();
    applyStimulus(1'b0, SEL_ADD4, 64'h0, 64'h0, 64'h0);
    busLat = 3;
    @(negedge clk);
    checkOutput("a4_ifv",        64'(if_valid),   64'h1);
    checkOutput("a4_if_pc",      if_pc, 64'h8000_2100);
    checkOutput("a4_if_inst",    64'(if_inst), 64'(instWord(64'h8000_2100)));
    checkOutput("a4_addr",       ireq_addr, 64'h8000_2104);

    // Reset mid-WAIT, with a redirect presented during reset.
    nextCycle();
    reset = 1'b1;
    applyStimulus(1'b1, SEL_JALR, 64'h0, 64'h0, 64'h8000_4000);
    @(negedge clk);
    checkOutput("mr_req",        64'(ireq_valid), 64'h0);
    checkOutput("mr_ifv",        64'(if_valid),   64'h0);
    checkOutput("mr_inst",       64'(if_inst),    64'h0);
    checkOutput("mr_pc",         if_pc,           64'h0);
    checkOutput("mr_flush",      64'(flush_out),  64'h0);
    checkOutput("mr_addr",       ireq_addr, RESET_PC_TB);
    nextCycle();
    applyStimulus(1'b0, SEL_ADD4, 64'h0, 64'h0, 64'h0);
    busLat = 1;
    nextCycle();
    reset = 1'b0;
    @(negedge clk);
    checkOutput("pr_req",        64'(ireq_valid), 64'h1);
    checkOutput("pr_addr",       ireq_addr, RESET_PC_TB);
    nextCycle();
    nextCycle();

    // Redirect to a target with bit 1 set.
    ireq_ready = 1'b0;
    applyStimulus(1'b1, SEL_ADD_IMM, 64'h8000_0000, 64'h2, 64'h0);
    @(negedge clk);
    checkOutput("ma_if_pc",      if_pc, RESET_PC_TB);
    checkOutput("ma_flush",      64'(flush_out),  64'h1);
    nextCycle();
    applyStimulus(1'b0, SEL_ADD4, 64'h0, 64'h0, 64'h0);
    @(negedge clk);
`ifdef PC_MISALIGN_TRAP_EN
    checkOutput("ma_trap",       64'(misalign_trap), 64'h1);
    checkOutput("ma_req",        64'(ireq_valid), 64'h0);
`else
    checkOutput("ma_req",        64'(ireq_valid), 64'h1);
    checkOutput("ma_addr",       ireq_addr, 64'h8000_0002);
`endif
    nextCycle();
    applyStimulus(1'b1, SEL_JALR, 64'h0, 64'h0, 64'h8000_0100);
    @(negedge clk);
`ifdef PC_MISALIGN_TRAP_EN
    checkOutput("ma_trap_hold",  64'(misalign_trap), 64'h1);
    checkOutput("ma_req_hold",   64'(ireq_valid), 64'h0);
`else
    checkOutput("ma_addr_hold",  ireq_addr, 64'h8000_0002);
`endif
    nextCycle();
    applyStimulus(1'b0, SEL_ADD4, 64'h0, 64'h0, 64'h0);
    @(negedge clk);
`ifdef PC_MISALIGN_TRAP_EN
    checkOutput("ma_trap_clr",   64'(misalign_trap), 64'h0);
`endif
    checkOutput("al_req",        64'(ireq_valid), 64'h1);
    checkOutput("al_addr",       ireq_addr, 64'h8000_0100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
- Fetch-side PC generator and instruction-fetch sequencer that consumes the branch-resolution result (flush + pcSelect) from the memory-stage branch checker.
- Owns the architectural fetch PC and issues single-outstanding requests on the instruction bus.
- Buffers one fetched instruction toward IF/ID.
- On a resolved redirect, computes the target, kills wrong-path state (including an in-flight bus response), and restarts fetch.

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, fetch PC loaded on reset.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- redirect_valid  in  1  branch_ctl.flush from branch checker
- pc_select  in  2  branch_ctl.pcSelect: PC_From_add4 / PC_From_add_imm / PC_From_jalr
- branch_pc  in  64  PC of the resolving instruction
- imm  in  64  sign-extended immediate of the resolving instruction
- jalr_base  in  64  forwarded rs1 value for jalr
- stall_in  in  1  downstream hazard stall; IF/ID not accepting
- ireq_valid  out  1  instruction bus request
- ireq_addr  out  64  request address
- ireq_ready  in  1  bus accepts request this cycle
- iresp_valid  in  1  response data valid
- iresp_data  in  32  fetched instruction word
- if_valid  out  1  buffered instruction valid toward IF/ID
- if_inst  out  32  buffered instruction
- if_pc  out  64  PC of buffered instruction
- flush_out  out  1  kill IF/ID and ID/EX this cycle

Behaviour:
- Reset (async, immediate):
  - pc=RESET_PC, state=IDLE, drop=0.
  - if_valid=0, if_inst=0, if_pc=0.
  - ireq_valid=0 while reset is high; flush_out=0.
  - Bus is reset by the same signal; no response survives reset.
- Redirect accept: take = redirect_valid && pc_select!=PC_From_add4. redirect_valid with PC_From_add4 is a no-op.
- Target, 64-bit wrap-around, no overflow detection:
  - PC_From_add_imm: branch_pc+imm.
  - PC_From_jalr: (jalr_base+imm) & ~64'h1.
- flush_out = take, combinational, same cycle.
- take has priority over every other event. Next edge:
  - pc<=target.
  - if_valid<=0.
- Buffer free condition: buf_free = !if_valid || !stall_in.
- State IDLE:
  - ireq_valid = buf_free && !take; ireq_addr = pc.
  - ireq_valid && ireq_ready -> WAIT.
  - ireq_valid held and ireq_addr stable until accepted.
- State WAIT:
  - ireq_valid=0.
  - iresp_valid && (drop || take): discard data, drop<=0, -> IDLE.
  - iresp_valid otherwise: if_inst<=iresp_data, if_pc<=pc, if_valid<=1, pc<=pc+4, -> IDLE.
  - take without iresp_valid: drop<=1, stay WAIT.
  - Repeated take while drop=1: pc updated again, drop stays 1.
- Consumption: if_valid && !stall_in and no new load that cycle -> if_valid<=0. Load and consume in the same cycle -> if_valid stays 1 with new contents.
- Latency: request issued at cycle N, response at N+k -> if_valid at N+k+1. Next request no earlier than N+k+1.
- Single outstanding request; the bus never returns iresp_valid outside WAIT (SVA assertion).

Optional Feature:
- Macro: PC_MISALIGN_TRAP_EN.
- Defined:
  - Extra output misalign_trap (1), registered.
  - Set when take && target[1:0]!=0.
  - Fetch halts: IDLE issues no requests until next take or reset.
  - Cleared by the next take or by reset.
- Undefined:
  - No port.
  - target used as-is; target[1] ignored by the block.

Test Plan:
- Reset then zero-wait bus (ireq_ready=1, response 1 cycle later) -> ireq_addr 0x80000000, 0x80000004, 0x80000008 with if_pc matching and if_valid one cycle after each response.
- stall_in=1 while if_valid=1 -> ireq_valid=0 and if_inst/if_pc held. Release stall -> request 0x8000000C issued that cycle.
- take in WAIT (pc_select=add_imm, branch_pc=0x80000010, imm=0x20), response arrives 3 cycles later -> flush_out=1 on the take cycle, response discarded, if_valid stays 0, next ireq_addr=0x80000030.
- take in IDLE same cycle as ireq_ready=1 (jalr, jalr_base=0x80001001, imm=0x4) -> no request accepted that cycle; next ireq_addr=0x80001004.
- take coincident with iresp_valid in WAIT -> data dropped, if_valid=0, fetch restarts at target. redirect_valid with PC_From_add4 -> flush_out=0, fetch sequence unchanged.
- reset asserted mid-WAIT -> outputs zero immediately; after deassert ireq_addr=0x80000000. With PC_MISALIGN_TRAP_EN, target 0x80000002 -> misalign_trap=1 and ireq_valid stays 0.
